mem_responder: RTL

//  Memory-side responder for the 16-bit datapath's memory interface. Accepts one request at a time
//  (instruction fetch or data load/store) over a valid/ready handshake. Returns read data or a write

---
 rtl/mem_responder_pkg.sv | 27 ++
 rtl/mem_array.sv | 37 +++
 rtl/mem_responder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// mem_responder_pkg
//   Shared types and constants for the memory responder.
//   - state_t       : responder FSM states (IDLE / WAIT / RESP)
//   - LATENCY_MIN/MAX: legal range of the LATENCY parameter
//   - CNT_W         : width of the latency down-counter
//   - latency_load(): counter preload value for a given latency
// ----------------------------------------------------------------------------
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

  // The counter holds the number of cycles still to spend in WAIT, so it is
  // preloaded with LATENCY-1 (at most 14, never wraps).
  function automatic logic [CNT_W-1:0] latency_load(input int latency);
    return CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// ----------------------------------------------------------------------------
// mem_array
//   Single-port word array, n bits x 2**DEPTH_LOG2 words. Writes are
//   synchronous; the read port is combinational so the responder can capture
//   read data into its own response register at the commit edge. Contents are
//   not reset.
// Ports
//   clk   in  1           clock, rising edge
//   we    in  1           write enable
//   addr  in  DEPTH_LOG2  word index
//   wdata in  n           write data
//   rdata out n           data at addr
// ----------------------------------------------------------------------------
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int n          = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [n-1:0]          wdata,
  output logic [n-1:0]          rdata
);

  logic [n-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the 16-bit datapath. Accepts one fetch/load/
//   store request at a time over valid/ready and answers after LATENCY cycles
//   with read data or a write acknowledge. Gives the multi-cycle core a slow
//   memory to stall on.
//
//   Optional feature, macro MEM_ERR_EN: misaligned (addr[0]=1) or out-of-range
//   (addr[n-1:DEPTH_LOG2+1]!=0) requests return rsp_err=1, rsp_rdata=0 and
//   suppress the write. Without it those address bits are ignored (aliasing
//   modulo depth) and rsp_err is always 0.
//
// Parameters
//   n           data/address width
//   DEPTH_LOG2  log2 of array depth in words
//   LATENCY     accept-to-response latency, 1..15
// Ports
//   clk        in   1  clock, rising edge
//   reset      in   1  asynchronous, active-high
//   req_valid  in   1  request present
//   req_ready  out  1  responder can accept (IDLE)
//   req_we     in   1  1 = write, 0 = read
//   req_addr   in   n  byte address; word index = req_addr[DEPTH_LOG2:1]
//   req_wdata  in   n  write data
//   rsp_valid  out  1  response present
//   rsp_ready  in   1  requester accepts response
//   rsp_rdata  out  n  read data, 0 for write responses
//   rsp_err    out  1  error flag
//   busy       out  1  transaction outstanding
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready=1
//   WAIT  | request latched, latency counter running
//   RESP  | response presented until rsp_ready
// ----------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int n          = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [n-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic         busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = latency_load(LATENCY);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 we_q;
  logic [n-1:0]         addr_q;
  logic [n-1:0]         wdata_q;

  logic                 accept;
  logic                 commit;
  logic                 c_we;
  logic [n-1:0]         c_addr;
  logic [n-1:0]         c_wdata;
  logic                 c_err;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [n-1:0]         arr_rdata;
  logic                 arr_we;

  assign accept = (state == IDLE) && req_valid && req_ready;

  // With LATENCY==1 the commit happens on the accept edge itself, so the
  // array is driven straight from the request inputs; otherwise from the
  // latched copy at the last WAIT edge (counter about to reach 0).
  assign commit = (LATENCY == 1) ? accept
                                 : ((state == WAIT) && (cnt == CNT_W'(1)));

  assign c_we    = (state == IDLE) ? req_we    : we_q;
  assign c_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign c_wdata = (state == IDLE) ? req_wdata : wdata_q;

  assign word_idx = c_addr[DEPTH_LOG2:1];

`ifdef MEM_ERR_EN
  assign c_err = c_addr[0] | (|c_addr[n-1:DEPTH_LOG2+1]);
`else
  // Alignment and range bits are don't-care in the aliasing build.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{c_addr[n-1:DEPTH_LOG2+1], c_addr[0]};
  assign c_err = 1'b0;
`endif

  // An uncommitted write never reaches the array, so a reset during WAIT
  // leaves the contents untouched.
  assign arr_we = commit && c_we && !c_err;

  mem_array #(
    .n          (n),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (word_idx),
    .wdata (c_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      // Response payload only changes at commit, so it is stable in RESP.
      if (commit) begin
        rsp_rdata <= (c_we || c_err) ? '0 : arr_rdata;
        rsp_err   <= c_err;
      end

      unique case (state)
        IDLE: begin
          if (accept) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            cnt       <= CNT_LOAD;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (LATENCY == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (commit) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
